// File: rtl/adder60_checker.sv
// rtl/adder60_checker.sv - two-stage error checker for the 60-bit duplicated carry-select adder
// Optional feature macro: ADDER60_CHK_PARITY_EN builds the parity checks and drives err_par.
module adder60_checker #(
   parameter int WIDTH       = 60,
   parameter int CNT_W       = 16,
   parameter int FAULT_THR   = 3,
   parameter int RECOVER_THR = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] s_invert,
   input  logic             papb,
   input  logic             pab,
   input  logic             clr_alarm,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_sum,
   output logic             err_comp,
   output logic             err_par,
   output logic             err_any,
   output logic [CNT_W-1:0] err_count,
   output logic [1:0]       alarm_state,
   output logic             fault
);

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_SUSPECT = 2'b01,
      ST_FAULT   = 2'b10
   } alarm_t;

   localparam logic [3:0] FAULT_T   = FAULT_THR[3:0];
   localparam logic [3:0] RECOVER_T = RECOVER_THR[3:0];

   // Stage 1 registers
   logic             s1_valid;
   logic [WIDTH-1:0] s1_s;
   logic [WIDTH-1:0] s1_sinv;

   // Check results computed from stage 1
   logic comp_bad;
   logic par_bad;

   // Alarm FSM and counters
   alarm_t     state, state_nxt;
   logic [3:0] run_cnt, run_nxt;
   logic [3:0] clean_cnt, clean_nxt;
   logic [CNT_W-1:0] count_nxt;

`ifdef ADDER60_CHK_PARITY_EN
   logic s1_papb;
   logic s1_pab;

   // Capture predicted parities alongside the sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_papb <= 1'b0;
         s1_pab  <= 1'b0;
      end else if (in_valid) begin
         s1_papb <= papb;
         s1_pab  <= pab;
      end
   end

   // Actual sum parity must match the true-rail prediction, and both rails must agree
   assign par_bad = ((^s1_s) != s1_pab) | (s1_papb != s1_pab);
`else
   // Parity inputs are intentionally dropped when the parity check is not built
   logic unused_parity;
   assign unused_parity = papb ^ pab;
   assign par_bad       = 1'b0;
`endif

   // Stage 1: valid always follows the input, data only loads on valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_s     <= '0;
         s1_sinv  <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_s    <= s;
            s1_sinv <= s_invert;
         end
      end
   end

   assign comp_bad = (s1_s != ~s1_sinv);

   // Stage 2: forward the sum and flag mismatches; flags are zero on idle cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         err_comp  <= 1'b0;
         err_par   <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         err_comp  <= s1_valid & comp_bad;
         err_par   <= s1_valid & par_bad;
         if (s1_valid) begin
            out_sum <= s1_s;
         end
      end
   end

   assign err_any = err_comp | err_par;

   // Alarm state, run/clean counters and error counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_OK;
         run_cnt   <= 4'd0;
         clean_cnt <= 4'd0;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         run_cnt   <= run_nxt;
         clean_cnt <= clean_nxt;
         err_count <= count_nxt;
      end
   end

   // Next-state logic: clr_alarm wins over any concurrent result
   always_comb begin
      state_nxt = state;
      run_nxt   = run_cnt;
      clean_nxt = clean_cnt;
      count_nxt = err_count;
      if (clr_alarm) begin
         state_nxt = ST_OK;
         run_nxt   = 4'd0;
         clean_nxt = 4'd0;
         count_nxt = '0;
      end else if (out_valid) begin
         if (err_any && (err_count != {CNT_W{1'b1}})) begin
            count_nxt = err_count + 1'b1;
         end
         case (state)
            ST_OK: begin
               if (err_any) begin
                  run_nxt   = 4'd1;
                  clean_nxt = 4'd0;
                  state_nxt = (FAULT_T <= 4'd1) ? ST_FAULT : ST_SUSPECT;
               end
            end
            ST_SUSPECT: begin
               if (err_any) begin
                  run_nxt   = run_cnt + 4'd1;
                  clean_nxt = 4'd0;
                  if ((run_cnt + 4'd1) >= FAULT_T) begin
                     state_nxt = ST_FAULT;
                  end
               end else begin
                  clean_nxt = clean_cnt + 4'd1;
                  run_nxt   = 4'd0;
                  if ((clean_cnt + 4'd1) >= RECOVER_T) begin
                     state_nxt = ST_OK;
                     clean_nxt = 4'd0;
                  end
               end
            end
            ST_FAULT: begin
               state_nxt = ST_FAULT;
            end
            default: begin
               state_nxt = ST_OK;
               run_nxt   = 4'd0;
               clean_nxt = 4'd0;
            end
         endcase
      end
   end

   assign alarm_state = state;
   assign fault       = (state == ST_FAULT);

endmodule

// File: tb/tb_adder60_checker.sv
// tb/tb_adder60_checker.sv - scoreboard bench for adder60_checker
module tb_adder60_checker;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [59:0] s;
   logic [59:0] s_invert;
   logic        papb;
   logic        pab;
   logic        clr_alarm;
   logic        out_valid;
   logic [59:0] out_sum;
   logic        err_comp;
   logic        err_par;
   logic        err_any;
   logic [15:0] err_count;
   logic [1:0]  alarm_state;
   logic        fault;

   typedef struct {
      logic [59:0] sum;
      logic        ecomp;
      logic        epar;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   errors;
   int   stray_valid;

`ifdef ADDER60_CHK_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   adder60_checker dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .s           (s),
      .s_invert    (s_invert),
      .papb        (papb),
      .pab         (pab),
      .clr_alarm   (clr_alarm),
      .out_valid   (out_valid),
      .out_sum     (out_sum),
      .err_comp    (err_comp),
      .err_par     (err_par),
      .err_any     (err_any),
      .err_count   (err_count),
      .alarm_state (alarm_state),
      .fault       (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare on every presented result
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            stray_valid++;
            chk("unexpected_out_valid", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_sum", {4'd0, out_sum}, {4'd0, e.sum});
            chk("err_comp", {63'd0, err_comp}, {63'd0, e.ecomp});
            chk("err_par", {63'd0, err_par}, {63'd0, e.epar});
            chk("err_any", {63'd0, err_any}, {63'd0, e.ecomp | e.epar});
         end
      end else if (rst_n) begin
         chk("idle_flags", {62'd0, err_comp, err_par}, 64'd0);
      end
   end

   task automatic send(input logic [59:0] sv, input logic [59:0] siv,
                       input logic pb, input logic pa, input logic ec, input logic ep);
      exp_t e;
      s        = sv;
      s_invert = siv;
      papb     = pb;
      pab      = pa;
      in_valid = 1'b1;
      e.sum    = sv;
      e.ecomp  = ec;
      e.epar   = ep & PAR_ON;
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_clr();
      clr_alarm = 1'b1;
      @(posedge clk); #1;
      clr_alarm = 1'b0;
   endtask

   task automatic chk_alarm(input string name, input logic [15:0] cnt, input logic [1:0] st);
      chk({name, "_count"}, {48'd0, err_count}, {48'd0, cnt});
      chk({name, "_state"}, {62'd0, alarm_state}, {62'd0, st});
      chk({name, "_fault"}, {63'd0, fault}, {63'd0, st == 2'b10});
   endtask

   localparam logic [59:0] GOOD = 60'h123;   // parity 0
   localparam logic [59:0] PODD = 60'h0F0;   // parity 0, paired with wrong pab=1

   initial begin
      checks      = 0;
      errors      = 0;
      stray_valid = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      s           = '0;
      s_invert    = '0;
      papb        = 1'b0;
      pab         = 1'b0;
      clr_alarm   = 1'b0;
      idle(2);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_sum", {4'd0, out_sum}, 64'd0);
      chk_alarm("rst", 16'd0, 2'b00);
      rst_n = 1'b1;
      idle(1);

      // Clean result
      send(GOOD, ~GOOD, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      chk_alarm("clean", 16'd0, 2'b00);

      // Single bit-5 flip on the complemented rail, then recovery
      send(GOOD, ~GOOD ^ 60'h20, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
      chk_alarm("flip", 16'd1, 2'b01);
      for (int i = 0; i < 3; i++) send(GOOD, ~GOOD, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      chk_alarm("recover3", 16'd1, 2'b01);
      send(GOOD, ~GOOD, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      chk_alarm("recover4", 16'd1, 2'b00);

      // Three wrong-parity results escalate to a sticky fault when parity is built
      pulse_clr();
      chk_alarm("clr1", 16'd0, 2'b00);
      for (int i = 0; i < 3; i++) send(PODD, ~PODD, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(3);
      if (PAR_ON) chk_alarm("par3", 16'd3, 2'b10);
      else        chk_alarm("par3", 16'd0, 2'b00);
      for (int i = 0; i < 10; i++) send(GOOD, ~GOOD, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      if (PAR_ON) chk_alarm("sticky", 16'd3, 2'b10);
      else        chk_alarm("sticky", 16'd0, 2'b00);
      pulse_clr();
      chk_alarm("clr2", 16'd0, 2'b00);

      // clr_alarm concurrent with an errored result
      send(GOOD, GOOD, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
      chk_alarm("pre_clr", 16'd1, 2'b01);
      send(GOOD, GOOD, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      chk("clr_concurrent_valid", {62'd0, out_valid, err_comp}, 64'd3);
      pulse_clr();
      idle(2);
      chk_alarm("clr_concurrent", 16'd0, 2'b00);

      // Counter saturation
      for (int i = 0; i < 65540; i++) send(60'd0, 60'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
      chk_alarm("saturate", 16'hFFFF, 2'b10);
      pulse_clr();
      chk_alarm("clr3", 16'd0, 2'b00);

      // Reset with two results in flight
      send(GOOD, GOOD, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
      chk_alarm("pre_rst", 16'd1, 2'b01);
      s = 60'hABC; s_invert = ~60'hABC; in_valid = 1'b1;
      @(posedge clk); #1;
      s = 60'hDEF; s_invert = ~60'hDEF;
      @(posedge clk); #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      idle(2);
      rst_n = 1'b1;
      stray_valid = 0;
      idle(5);
      chk("rst_no_valid", 64'(stray_valid), 64'd0);
      chk("rst_out_valid2", {63'd0, out_valid}, 64'd0);
      chk("rst_out_sum2", {4'd0, out_sum}, 64'd0);
      chk("rst_flags2", {61'd0, err_comp, err_par, err_any}, 64'd0);
      chk_alarm("rst2", 16'd0, 2'b00);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
